// File: rtl/gain_ramp.sv
// gain_ramp: scales CHANNELS signed samples by a shared, slew-limited gain.
// Two-stage pipeline: multiply register, then shift/output register.
module gain_ramp #(
    parameter int WIDTH     = 20,
    parameter int GAIN_W    = 8,
    parameter int CHANNELS  = 2,
    parameter int INIT_GAIN = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] wave_in,
    input  logic [GAIN_W-1:0]         target_gain,
    input  logic [GAIN_W-1:0]         ramp_step,
    input  logic                      mute,
    output logic [CHANNELS*WIDTH-1:0] wave_out,
    output logic                      out_valid,
    output logic [GAIN_W-1:0]         gain_cur,
    output logic                      ramp_busy
);

    localparam int PW = WIDTH + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = '1;

    logic [GAIN_W-1:0]         gain_q, gain_d;
    logic [GAIN_W-1:0]         tgt;
    logic                      v1_q, v1_d;
    logic                      v2_q, v2_d;
    logic signed [PW-1:0]      prod_q [CHANNELS];
    logic signed [PW-1:0]      prod_d [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] wave_q, wave_d;
    logic [GAIN_W+1:0]         mult;

    // Effective target: mute forces a fade to zero
    always_comb tgt = mute ? '0 : target_gain;

    // Slew-limited gain update, only on an accepted frame; never overshoots
    always_comb begin
        gain_d = gain_q;
        if (sample_valid) begin
            if (ramp_step == '0 || gain_q == tgt) begin
                gain_d = tgt;
            end else if (gain_q < tgt) begin
                if (ramp_step >= tgt - gain_q) gain_d = tgt;
                else                            gain_d = gain_q + ramp_step;
            end else begin
                if (ramp_step >= gain_q - tgt) gain_d = tgt;
                else                            gain_d = gain_q - ramp_step;
            end
        end
    end

    // Stage 1: per-channel product with the pre-update gain.
    // Unity gain multiplies by 2^GAIN_W so the stage-2 shift returns the input
    // bit-exact; this folds the bypass select into the multiplier operand.
    always_comb begin
        mult = (gain_q == UNITY) ? {2'b01, {GAIN_W{1'b0}}} : {2'b00, gain_q};
        v1_d = sample_valid;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            prod_d[k] = prod_q[k];
            if (sample_valid)
                prod_d[k] = PW'($signed(wave_in[k*WIDTH +: WIDTH])) * PW'($signed(mult));
        end
    end

    // Stage 2: arithmetic shift back to sample width; output holds between frames
    always_comb begin
        v2_d   = v1_q;
        wave_d = wave_q;
        if (v1_q) begin
            for (int unsigned k = 0; k < CHANNELS; k++)
                wave_d[k*WIDTH +: WIDTH] = WIDTH'(prod_q[k] >>> GAIN_W);
        end
    end

    // State registers; reset discards in-flight frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_q <= GAIN_W'(INIT_GAIN);
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            wave_q <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) prod_q[k] <= '0;
        end else begin
            gain_q <= gain_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            wave_q <= wave_d;
            for (int unsigned k = 0; k < CHANNELS; k++) prod_q[k] <= prod_d[k];
        end
    end

    assign wave_out  = wave_q;
    assign out_valid = v2_q;
    assign gain_cur  = gain_q;
    assign ramp_busy = (gain_q != tgt);

endmodule
